// File: rtl/mem_resp_pkg.sv
// Shared sizes and helpers for the two-port memory responder.
// Optional feature: MEM_PARITY_EN adds one even-parity bit per stored word.
package mem_resp_pkg;
  localparam int SIZE_ADDR           = 16;
  localparam int SIZE_DATA           = 16;
  localparam int SIZE_MEM_DEPTH_LOG2 = 12;
  localparam int NUM_PORTS           = 2;

`ifdef MEM_PARITY_EN
  localparam int WORD_W = SIZE_DATA + 1;
`else
  localparam int WORD_W = SIZE_DATA;
`endif

  // Build the stored word; the parity bit (when present) makes the total even.
  function automatic logic [WORD_W-1:0] encode_word(input logic [SIZE_DATA-1:0] data);
`ifdef MEM_PARITY_EN
    return {^data, data};
`else
    return data;
`endif
  endfunction
endpackage

// File: rtl/mem_bank.sv
// Storage array: one clocked write process (two commit lanes) and two
// asynchronous read ports. No reset on the contents.
module mem_bank
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = SIZE_MEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we    [0:1],
  input  logic [DEPTH_LOG2-1:0] waddr [0:1],
  input  logic [WORD_W-1:0]     wword [0:1],
  input  logic [DEPTH_LOG2-1:0] raddr [0:1],
  output logic [WORD_W-1:0]     rword [0:1]
);
  logic [WORD_W-1:0] mem_q [0:(2**DEPTH_LOG2)-1];

  // Lane 1 is written first so lane 0 overwrites it on an address collision.
  always_ff @(posedge clk) begin
    if (we[1]) mem_q[waddr[1]] <= wword[1];
    if (we[0]) mem_q[waddr[0]] <= wword[0];
  end

  assign rword[0] = mem_q[raddr[0]];
  assign rword[1] = mem_q[raddr[1]];
endmodule

// File: rtl/mem_resp.sv
// Two-port memory responder: address phase latches the request, data phase
// returns the word one cycle later. Writes are posted into a one-deep pending
// slot per port and committed the cycle after; reads forward from those slots.
// Optional feature: MEM_PARITY_EN (adds ow_mem_perr and parity checking).
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = SIZE_MEM_DEPTH_LOG2
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst,
  input  logic [SIZE_ADDR-1:0] iw_mem_addr  [0:1],
  input  logic                 iw_mem_re    [0:1],
  input  logic                 iw_mem_we    [0:1],
  input  logic [SIZE_DATA-1:0] iw_mem_wdata [0:1],
  output logic [SIZE_DATA-1:0] ow_mem_rdata [0:1]
`ifdef MEM_PARITY_EN
  ,
  output logic                 ow_mem_perr  [0:1]
`endif
);
  logic [DEPTH_LOG2-1:0] a_q     [0:1];
  logic [DEPTH_LOG2-1:0] a_d     [0:1];
  logic                  re_q    [0:1];
  logic                  re_d    [0:1];
  logic                  pvld_q  [0:1];
  logic                  pvld_d  [0:1];
  logic [DEPTH_LOG2-1:0] paddr_q [0:1];
  logic [DEPTH_LOG2-1:0] paddr_d [0:1];
  logic [SIZE_DATA-1:0]  pdata_q [0:1];
  logic [SIZE_DATA-1:0]  pdata_d [0:1];

  logic                  bank_we    [0:1];
  logic [WORD_W-1:0]     bank_wword [0:1];
  logic [WORD_W-1:0]     bank_rword [0:1];

  // Address bits above the decoded depth are deliberately dropped (wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^{iw_mem_addr[0][SIZE_ADDR-1:DEPTH_LOG2],
                            iw_mem_addr[1][SIZE_ADDR-1:DEPTH_LOG2]};

  // Next-state: latch address phase, post this cycle's write against a_q.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      a_d[p]     = iw_mem_addr[p][DEPTH_LOG2-1:0];
      re_d[p]    = iw_mem_re[p];
      pvld_d[p]  = iw_mem_we[p];
      paddr_d[p] = a_q[p];
      pdata_d[p] = iw_mem_wdata[p];
    end
  end

  // State registers; reset drops the request and any pending write.
  always_ff @(posedge iw_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      paddr_q[p] <= paddr_d[p];
      pdata_q[p] <= pdata_d[p];
      if (iw_rst) begin
        a_q[p]    <= '0;
        re_q[p]   <= 1'b0;
        pvld_q[p] <= 1'b0;
      end else begin
        a_q[p]    <= a_d[p];
        re_q[p]   <= re_d[p];
        pvld_q[p] <= pvld_d[p];
      end
    end
  end

  // Commit pending writes; a reset edge must not let a pending write land.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bank_we[p]    = pvld_q[p] & ~iw_rst;
      bank_wword[p] = encode_word(pdata_q[p]);
    end
  end

  mem_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
    .clk   (iw_clk),
    .we    (bank_we),
    .waddr (paddr_q),
    .wword (bank_wword),
    .raddr (a_q),
    .rword (bank_rword)
  );

  // Data phase: pending slot 0 beats slot 1 beats storage; idle ports read 0.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      ow_mem_rdata[p] = '0;
`ifdef MEM_PARITY_EN
      ow_mem_perr[p]  = 1'b0;
`endif
      if (re_q[p]) begin
        if (pvld_q[0] && (paddr_q[0] == a_q[p])) begin
          ow_mem_rdata[p] = pdata_q[0];
        end else if (pvld_q[1] && (paddr_q[1] == a_q[p])) begin
          ow_mem_rdata[p] = pdata_q[1];
        end else begin
          ow_mem_rdata[p] = bank_rword[p][SIZE_DATA-1:0];
`ifdef MEM_PARITY_EN
          ow_mem_perr[p]  = ^bank_rword[p];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: a per-cycle vector table plus hand-written
// sequences for reset-during-pending-write and (optionally) parity.
module tb_mem_resp;
  import mem_resp_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [SIZE_ADDR-1:0] addr  [0:1];
  logic                 re    [0:1];
  logic                 we    [0:1];
  logic [SIZE_DATA-1:0] wdata [0:1];
  logic [SIZE_DATA-1:0] rdata [0:1];
`ifdef MEM_PARITY_EN
  logic                 perr  [0:1];
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_resp #(.DEPTH_LOG2(12)) dut (
    .iw_clk       (clk),
    .iw_rst       (rst),
    .iw_mem_addr  (addr),
    .iw_mem_re    (re),
    .iw_mem_we    (we),
    .iw_mem_wdata (wdata),
    .ow_mem_rdata (rdata)
`ifdef MEM_PARITY_EN
    ,
    .ow_mem_perr  (perr)
`endif
  );

  // One row per cycle: inputs driven that cycle, and the rdata expected in
  // that same cycle (data phase of the previous row's address).
  typedef struct {
    logic [15:0] a0; logic re0; logic we0; logic [15:0] wd0;
    logic [15:0] a1; logic re1; logic we1; logic [15:0] wd1;
    logic [15:0] e0; logic [15:0] e1;
  } vec_t;

  function automatic vec_t v(input logic [15:0] a0, input logic re0, input logic we0,
                             input logic [15:0] wd0, input logic [15:0] a1, input logic re1,
                             input logic we1, input logic [15:0] wd1,
                             input logic [15:0] e0, input logic [15:0] e1);
    vec_t r;
    r.a0 = a0; r.re0 = re0; r.we0 = we0; r.wd0 = wd0;
    r.a1 = a1; r.re1 = re1; r.we1 = we1; r.wd1 = wd1;
    r.e0 = e0; r.e1 = e1;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    addr[0] = r.a0; re[0] = r.re0; we[0] = r.we0; wdata[0] = r.wd0;
    addr[1] = r.a1; re[1] = r.re1; we[1] = r.we1; wdata[1] = r.wd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t tbl [26];

  initial begin
    //          a0     re we wd0       a1     re we wd1       e0       e1
    tbl[0]  = v(16'h0005,0,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h0000,16'h0000);
    tbl[1]  = v(16'h0000,0,1,16'h1234, 16'h0000,0,0,16'h0000, 16'h0000,16'h0000);
    tbl[2]  = v(16'h0000,0,0,16'h0000, 16'h0005,1,0,16'h0000, 16'h0000,16'h0000);
    tbl[3]  = v(16'h0000,0,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h0000,16'h1234);
    tbl[4]  = v(16'h0007,0,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h0000,16'h0000);
    tbl[5]  = v(16'h0000,0,1,16'hAAAA, 16'h0007,1,0,16'h0000, 16'h0000,16'h0000);
    tbl[6]  = v(16'h0007,1,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h0000,16'hAAAA);
    tbl[7]  = v(16'h0000,0,0,16'h0000, 16'h0000,0,0,16'h0000, 16'hAAAA,16'h0000);
    tbl[8]  = v(16'h0003,0,0,16'h0000, 16'h0003,0,0,16'h0000, 16'h0000,16'h0000);
    tbl[9]  = v(16'h0003,1,1,16'h0001, 16'h0003,1,1,16'h0002, 16'h0000,16'h0000);
    tbl[10] = v(16'h0000,0,0,16'h0000, 16'h0003,1,0,16'h0000, 16'h0001,16'h0001);
    tbl[11] = v(16'h0000,0,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h0000,16'h0001);
    tbl[12] = v(16'h0014,0,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h0000,16'h0000);
    tbl[13] = v(16'h0000,0,1,16'h0BEE, 16'h0000,0,0,16'h0000, 16'h0000,16'h0000);
    tbl[14] = v(16'h0014,1,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h0000,16'h0000);
    tbl[15] = v(16'h0014,1,1,16'h0CAF, 16'h0000,0,0,16'h0000, 16'h0BEE,16'h0000);
    tbl[16] = v(16'h0014,1,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h0CAF,16'h0000);
    tbl[17] = v(16'h0000,0,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h0CAF,16'h0000);
    tbl[18] = v(16'h1004,0,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h0000,16'h0000);
    tbl[19] = v(16'h0000,0,1,16'h4444, 16'h0004,1,0,16'h0000, 16'h0000,16'h0000);
    tbl[20] = v(16'hF004,1,0,16'h0000, 16'h1004,1,0,16'h0000, 16'h0000,16'h4444);
    tbl[21] = v(16'h0000,0,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h4444,16'h4444);
    tbl[22] = v(16'h0000,0,0,16'h0000, 16'h001E,0,0,16'h0000, 16'h0000,16'h0000);
    tbl[23] = v(16'h001E,1,0,16'h0000, 16'h0000,0,1,16'h3030, 16'h0000,16'h0000);
    tbl[24] = v(16'h001E,1,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h3030,16'h0000);
    tbl[25] = v(16'h0000,0,0,16'h0000, 16'h0000,0,0,16'h0000, 16'h3030,16'h0000);

    // Reset state
    rst = 1'b1;
    drive(v(0,0,0,0, 0,0,0,0, 0,0));
    step();
    step();
    chk("reset rdata0", rdata[0], 16'h0000);
    chk("reset rdata1", rdata[1], 16'h0000);

    // Table: first row is the first cycle with reset low
    rst = 1'b0;
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d port0", i), rdata[0], tbl[i].e0);
      chk($sformatf("row%0d port1", i), rdata[1], tbl[i].e1);
      step();
    end

    // Reset while pend[0] holds addr 9 = 0x5555; old value 0x0909 must survive
    drive(v(16'h0009,0,0,16'h0000, 0,0,0,0, 0,0)); step();
    drive(v(16'h0000,0,1,16'h0909, 0,0,0,0, 0,0)); step();
    drive(v(16'h0000,0,0,16'h0000, 0,0,0,0, 0,0)); step();
    drive(v(16'h0009,0,0,16'h0000, 0,0,0,0, 0,0)); step();
    drive(v(16'h0009,1,1,16'h5555, 0,0,0,0, 0,0)); step();
    chk("pending fwd before reset", rdata[0], 16'h5555);
    rst = 1'b1;
    drive(v(0,0,0,0, 0,0,0,0, 0,0));
    step();
    chk("rdata0 in reset c1", rdata[0], 16'h0000);
    chk("rdata1 in reset c1", rdata[1], 16'h0000);
    step();
    chk("rdata0 in reset c2", rdata[0], 16'h0000);
    rst = 1'b0;
    drive(v(16'h0009,1,0,16'h0000, 0,0,0,0, 0,0)); step();
    drive(v(0,0,0,0, 0,0,0,0, 0,0));
    chk("addr9 after reset", rdata[0], 16'h0909);
    step();
    chk("idle after reset read", rdata[0], 16'h0000);

`ifdef MEM_PARITY_EN
    // Corrupt the stored parity bit of addr 11 and read it once
    drive(v(16'h000B,0,0,16'h0000, 0,0,0,0, 0,0)); step();
    drive(v(16'h0000,0,1,16'h00B0, 0,0,0,0, 0,0)); step();
    drive(v(16'h0000,0,0,16'h0000, 0,0,0,0, 0,0)); step();
    dut.u_bank.mem_q[11][SIZE_DATA] = ~dut.u_bank.mem_q[11][SIZE_DATA];
    drive(v(16'h000B,1,0,16'h0000, 0,0,0,0, 0,0)); step();
    drive(v(0,0,0,0, 0,0,0,0, 0,0));
    chk("perr data phase", {15'h0, perr[0]}, 16'h0001);
    chk("perr rdata", rdata[0], 16'h00B0);
    step();
    chk("perr after", {15'h0, perr[0]}, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
